// File: rtl/riscv_pkg.sv
// Shared types for the core's memory-side blocks:
// arbiter state/owner encodings and access-size codes.
package riscv_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } arb_owner_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter in front of one fixed-latency memory port.
// One access in flight; data has priority, bounded by a starvation guard.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [31:0]   if_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [1:0]    d_size_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [31:0]   d_wdata_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic [31:0]   d_rdata_o,
  output logic          m_req_o,
  output logic          m_we_o,
  output logic [1:0]    m_size_o,
  output logic [AW-1:0] m_addr_o,
  output logic [31:0]   m_wdata_o,
  input  logic [31:0]   m_rdata_i
);

  localparam int LW = 3;
  localparam int SW = (STARVE_MAX < 2) ? 1
                    : $clog2(STARVE_MAX + 1);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          st_we_q, st_we_d;

  logic done;
  logic can_gnt;
  logic starved;
  logic gnt_if;
  logic gnt_d;

  // Priority pick: data first unless fetch has waited STARVE_MAX grants.
  // Reset blanks every grant so nothing launches while rst is high.
  always_comb begin
    done    = (state_q == BUSY) && (lat_q == '0);
    can_gnt = !rst && ((state_q == IDLE) || done);
    starved = (starve_q == SW'(STARVE_MAX));
    gnt_if  = can_gnt && if_req_i && (!d_req_i || starved);
    gnt_d   = can_gnt && d_req_i && !gnt_if;
  end

  // State register plus the owner/latency/starvation bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      lat_q    <= '0;
      starve_q <= '0;
      st_we_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      st_we_q  <= st_we_d;
    end
  end

  // Next state: a grant (re)arms the countdown, else count down or idle.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    lat_d    = lat_q;
    starve_d = starve_q;
    st_we_d  = st_we_q;
    if (gnt_if || gnt_d) begin
      state_d = BUSY;
      lat_d   = LW'(LAT - 1);
      owner_d = gnt_if ? OWN_IF : OWN_D;
      st_we_d = gnt_d && d_we_i;
      if (gnt_d && if_req_i)
        starve_d = starved ? starve_q
                           : starve_q + SW'(1);
      else
        starve_d = '0;
    end else if (done) begin
      state_d = IDLE;
      owner_d = OWN_NONE;
      st_we_d = 1'b0;
    end else if (state_q == BUSY) begin
      lat_d = lat_q - LW'(1);
    end
  end

  // Outputs: launch the winner, return the completing access to its owner.
  always_comb begin
    if_gnt_o    = 1'b0;
    d_gnt_o     = 1'b0;
    m_req_o     = 1'b0;
    m_we_o      = 1'b0;
    m_size_o    = 2'b00;
    m_addr_o    = '0;
    m_wdata_o   = '0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = '0;
    if (gnt_if) begin
      if_gnt_o = 1'b1;
      m_req_o  = 1'b1;
      m_size_o = SZ_WORD;
      m_addr_o = if_addr_i;
    end else if (gnt_d) begin
      d_gnt_o   = 1'b1;
      m_req_o   = 1'b1;
      m_we_o    = d_we_i;
      m_size_o  = d_size_i;
      m_addr_o  = d_addr_i;
      m_wdata_o = d_wdata_i;
    end
    if (done && !rst) begin
      if (owner_q == OWN_IF) begin
        if_rvalid_o = 1'b1;
        if_rdata_o  = m_rdata_i;
      end else if (owner_q == OWN_D) begin
        d_rvalid_o = 1'b1;
        d_rdata_o  = st_we_q ? 32'h0 : m_rdata_i;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the instruction-fetch requester and the load/store requester of the riscv core.
- Sits between imem/mem-stage front ends and the physical memory array.
- Grants one transaction at a time and tracks the in-flight latency with a counter FSM.
- Routes the response back to the owner; a starvation guard prevents data traffic from locking out fetch.

Parameters:
- LAT, 2, memory read latency in cycles, legal range 1..8. m_rdata_i is valid LAT cycles after the m_req_o cycle.
- STARVE_MAX, 4, maximum consecutive data grants while a fetch is pending; legal range ≥1.
- AW, 32, address width.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch request; held stable until if_gnt_o
- if_addr_i  in  AW  fetch address
- if_gnt_o  out  1  fetch granted this cycle
- if_rvalid_o  out  1  fetch response valid (1-cycle pulse)
- if_rdata_o  out  32  fetch instruction word
- d_req_i  in  1  data request; held stable until d_gnt_o
- d_we_i  in  1  1 = store, 0 = load
- d_size_i  in  2  00 byte, 01 half, 10 word
- d_addr_i  in  AW  data address
- d_wdata_i  in  32  store data
- d_gnt_o  out  1  data granted this cycle
- d_rvalid_o  out  1  data response / store ack (1-cycle pulse)
- d_rdata_o  out  32  load data
- m_req_o  out  1  memory access launch
- m_we_o  out  1  memory write enable
- m_size_o  out  2  memory access size
- m_addr_o  out  AW  memory address
- m_wdata_o  out  32  memory write data
- m_rdata_i  in  32  memory read data

Behaviour:
- Reset (rst=1 at clock edge): FSM=IDLE, lat_cnt=0, owner=NONE, starve_cnt=0. All outputs are 0 during and after reset until a new grant. Any in-flight response is discarded and no rvalid is emitted for it.
- States:
  - IDLE: no outstanding access.
  - BUSY: one access outstanding; lat_cnt counts down from LAT-1.
- Grant decision, evaluated combinationally when FSM=IDLE, or in the BUSY completion cycle (lat_cnt==0):
  - only one request → grant it;
  - both requests → grant data, unless starve_cnt==STARVE_MAX, in which case grant fetch.
- Grant cycle:
  - assert gnt of the winner and m_req_o;
  - drive m_we_o/m_size_o/m_addr_o/m_wdata_o from the winner's inputs;
  - fetch grants force m_we_o=0 and m_size_o=10;
  - next state is BUSY with lat_cnt=LAT-1 and owner=winner.
- BUSY with lat_cnt>0: decrement; no grants issued; m_* outputs are 0.
- BUSY with lat_cnt==0 (completion):
  - pulse the owner's rvalid and drive its rdata=m_rdata_i;
  - a store acks with rdata=0;
  - non-owner rdata=0.
  - A new grant may issue in the same cycle (back-to-back, no bubble); otherwise go to IDLE.
- Throughput: one access per LAT cycles. Latency from gnt to rvalid is exactly LAT cycles.
- rdata outputs are 0 whenever their rvalid is 0.
- Starvation counter, updated on each grant:
  - data grant while if_req_i=1 → starve_cnt+1, saturating at STARVE_MAX;
  - fetch grant, or if_req_i=0 → starve_cnt=0.
- Requests dropped before grant are a protocol violation; the bench asserts this never happens.
- gnt_o of both requesters is never 1 in the same cycle; rvalid likewise.
- Addresses pass through unmodified; no alignment checking in this block.

Decomposition:
- riscv_pkg holds:
  - arb_state_t {IDLE, BUSY};
  - arb_owner_t {OWN_NONE, OWN_IF, OWN_D};
  - size constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, shared with mem/control_logic.
- No sub-module: the priority picker and counters stay inline; the FSM is small.

Test Plan (LAT=2, STARVE_MAX=4):
- Fetch only: if_req_i=1, if_addr_i=0x10 at cycle 0 → if_gnt_o=1 and m_addr_o=0x10, m_we_o=0 at cycle 0; if_rvalid_o=1 with if_rdata_o=m_rdata_i (e.g. 0x00500093) at cycle 2.
- Simultaneous requests, both presented at cycle 0: d load at 0x40 and fetch at 0x14 → data granted at cycle 0; d_rvalid at cycle 2; fetch granted at cycle 2 (back-to-back); if_rvalid at cycle 4.
- Store ack: d_we_i=1, d_size_i=00, d_addr_i=0x21, d_wdata_i=0xAB → m_we_o=1, m_size_o=00 in the grant cycle; d_rvalid_o=1 with d_rdata_o=0 two cycles later.
- Starvation: d_req_i and if_req_i held high continuously → exactly 4 consecutive data grants, then 1 fetch grant, then the pattern repeats.
- Reset mid-operation: rst=1 one cycle after a grant → no rvalid ever emitted for that access; all outputs 0; next request after rst=0 is granted normally.
- LAT=1 variant: continuous fetch stream → one grant and one rvalid per cycle, rvalid trailing the grant by 1 cycle.
